// File: rtl/banner_pkg.sv
// Shared types and constant tables for the end-of-round banner: character codes,
// message rows, glyph bitmaps and the reveal state encoding.
package banner_pkg;

    typedef logic [3:0] char_code_t;

    localparam char_code_t SPACE = 4'd0;
    localparam char_code_t W     = 4'd1;
    localparam char_code_t I     = 4'd2;
    localparam char_code_t N     = 4'd3;
    localparam char_code_t P     = 4'd4;
    localparam char_code_t ONE   = 4'd5;
    localparam char_code_t TWO   = 4'd6;
    localparam char_code_t S     = 4'd7;
    localparam char_code_t T     = 4'd8;
    localparam char_code_t E     = 4'd9;
    localparam char_code_t G     = 4'd10;
    localparam char_code_t A     = 4'd11;
    localparam char_code_t M     = 4'd12;

    localparam int MSG_LEN   = 8;
    localparam int MSG_IDX_W = $clog2(MSG_LEN);

    localparam char_code_t MSG_TABLE [4][MSG_LEN] = '{
        '{P, ONE, SPACE, W, I, N, S, SPACE},
        '{P, TWO, SPACE, W, I, N, S, SPACE},
        '{T, I, E, SPACE, G, A, M, E},
        '{default: SPACE}
    };

    // One 8x16 glyph per entry; row 0 is the most significant byte, bit 7 of a row is leftmost.
    localparam logic [127:0] GLYPH_BITS [16] = '{
        128'h0,
        128'h0000_C6C6_C6C6_C6D6_D6D6_FEEE_C682_0000,
        128'h0000_7E18_1818_1818_1818_1818_187E_0000,
        128'h0000_C6E6_E6F6_F6DE_DECE_CEC6_C6C6_0000,
        128'h0000_FCC6_C6C6_C6FC_C0C0_C0C0_C0C0_0000,
        128'h0000_1838_7818_1818_1818_1818_187E_0000,
        128'h0000_7CC6_0606_0C18_3060_C0C0_C6FE_0000,
        128'h0000_7CC6_C0C0_6038_0C06_0606_C67C_0000,
        128'h0000_FFDB_1818_1818_1818_1818_183C_0000,
        128'h0000_FEC6_C0C0_C8F8_C8C0_C0C0_C6FE_0000,
        128'h0000_3C66_C2C0_C0DE_C6C6_C6C6_663A_0000,
        128'h0000_1038_6CC6_C6C6_FEC6_C6C6_C6C6_0000,
        128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_C6C6_0000,
        128'h0,
        128'h0,
        128'h0
    };

    typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;

    // Cells past the stored row length read as blanks so wider boxes stay padded.
    function automatic char_code_t msg_code(input logic [1:0] msg, input logic [7:0] idx);
        if (idx < 8'(MSG_LEN)) begin
            return MSG_TABLE[msg][idx[MSG_IDX_W-1:0]];
        end
        return SPACE;
    endfunction

endpackage

// File: rtl/banner_glyph_rom.sv
// Combinational glyph ROM: returns one 8-pixel row of the selected character.
module banner_glyph_rom
    import banner_pkg::*;
(
    input  char_code_t  code,
    input  logic [3:0]  row,
    output logic [7:0]  data
);

    logic [127:0] glyph;

    always_comb begin
        glyph = GLYPH_BITS[code];
        // Row r occupies bits [127-8r -: 8], and 127-8r == {~r, 3'b111}.
        data  = glyph[{~row, 3'b111} -: 8];
    end

endmodule

// File: rtl/banner_text_renderer.sv
// End-of-round banner: typewriter reveal and blink control plus a two-stage
// pixel pipeline that turns DrawX/DrawY into a registered foreground bit.
module banner_text_renderer
    import banner_pkg::*;
#(
    parameter int N_CHARS       = 8,
    parameter int SCALE_LOG2    = 1,
    parameter int ORIGIN_X      = 256,
    parameter int ORIGIN_Y      = 200,
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       show,
    input  logic [1:0] msg_sel,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       pixel_on,
    output logic       reveal_done
);

    localparam int BOX_W  = (N_CHARS * 8) << SCALE_LOG2;
    localparam int BOX_H  = 16 << SCALE_LOG2;
    localparam int FC_MAX = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
    localparam int FC_W   = (FC_MAX > 1) ? $clog2(FC_MAX) : 1;

    localparam logic [FC_W-1:0] REVEAL_LAST = FC_W'(REVEAL_FRAMES - 1);
    localparam logic [FC_W-1:0] BLINK_LAST  = FC_W'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

    state_t          state;
    logic [FC_W-1:0] frame_cnt;
    logic [7:0]      reveal_count;
    logic            blink_on;
    logic [1:0]      msg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            reveal_count <= '0;
            blink_on     <= 1'b1;
            msg          <= '0;
            reveal_done  <= 1'b0;
        end else if (!show) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            reveal_count <= '0;
            blink_on     <= 1'b1;
            reveal_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state        <= REVEAL;
                    msg          <= msg_sel;
                    reveal_count <= 8'd1;
                    frame_cnt    <= '0;
                    reveal_done  <= 1'b0;
                end
                REVEAL: begin
                    // Only reachable with a single-cell message: already fully shown.
                    if (reveal_count >= 8'(N_CHARS)) begin
                        state       <= HOLD;
                        frame_cnt   <= '0;
                        blink_on    <= 1'b1;
                        reveal_done <= 1'b1;
                    end else if (frame_start) begin
                        if (frame_cnt == REVEAL_LAST) begin
                            frame_cnt    <= '0;
                            reveal_count <= reveal_count + 8'd1;
                            if (reveal_count + 8'd1 == 8'(N_CHARS)) begin
                                state       <= HOLD;
                                blink_on    <= 1'b1;
                                reveal_done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    reveal_done <= 1'b1;
                    if (BLINK_FRAMES > 0 && frame_start) begin
                        if (frame_cnt == BLINK_LAST) begin
                            frame_cnt <= '0;
                            blink_on  <= ~blink_on;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    reveal_done <= 1'b0;
                end
            endcase
        end
    end

    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic        inside_c;
    logic [7:0]  char_idx_c;
    logic [2:0]  col_c;
    logic [3:0]  row_c;
    logic        visible_c;

    always_comb begin
        rel_x      = {1'b0, DrawX} - 11'(ORIGIN_X);
        rel_y      = {1'b0, DrawY} - 11'(ORIGIN_Y);
        inside_c   = !rel_x[10] && (rel_x < 11'(BOX_W)) && !rel_y[10] && (rel_y < 11'(BOX_H));
        char_idx_c = 8'(rel_x >> (3 + SCALE_LOG2));
        col_c      = 3'(rel_x >> SCALE_LOG2);
        row_c      = 4'(rel_y >> SCALE_LOG2);
        // Gating on show keeps a stale stage-1 entry from lighting a pixel after a drop.
        visible_c  = show && (((state == REVEAL) && (char_idx_c < reveal_count)) ||
                              ((state == HOLD) && blink_on));
    end

    logic       s1_inside;
    logic [7:0] s1_char_idx;
    logic [2:0] s1_col;
    logic [3:0] s1_row;
    logic       s1_visible;
    char_code_t s2_code;
    logic [7:0] glyph_row;

    assign s2_code = msg_code(msg, s1_char_idx);

    banner_glyph_rom u_rom (
        .code (s2_code),
        .row  (s1_row),
        .data (glyph_row)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_inside   <= 1'b0;
            s1_char_idx <= '0;
            s1_col      <= '0;
            s1_row      <= '0;
            s1_visible  <= 1'b0;
            pixel_on    <= 1'b0;
        end else begin
            s1_inside   <= inside_c;
            s1_char_idx <= char_idx_c;
            s1_col      <= col_c;
            s1_row      <= row_c;
            s1_visible  <= visible_c;
            pixel_on    <= show && s1_inside && s1_visible && glyph_row[~s1_col];
        end
    end

endmodule
